// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency single-port memory between instruction fetch and data access.
module mem_port_arbiter #(
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [DATA_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [DATA_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              mem_en,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int CW = $clog2(MEM_LAT + 1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  state_e            state_q, state_d;
  // owner/last_grant encoding: 1 = DATA, 0 = IFETCH
  logic              owner_q, last_q, we_q;
  logic [CW-1:0]     cnt_q;
  logic [DATA_W-1:0] addr_q, wdata_q, if_rdata_q, d_rdata_q;
  logic              any_req, gnt_d, last_beat;
  assign any_req   = if_req | d_req;
  assign gnt_d     = d_req & (~if_req | ~last_q);
  assign last_beat = (state_q == BUSY) && (cnt_q == CW'(1));
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign stall_if  = if_req & ~if_valid;
  assign stall_mem = d_req & ~d_valid;
  always_comb begin
    state_d   = state_q;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if_valid  = 1'b0;
    d_valid   = 1'b0;
    case (state_q)
      IDLE: state_d = any_req ? BUSY : IDLE;
      BUSY: begin
        state_d   = last_beat ? DONE : BUSY;
        mem_en    = 1'b1;
        mem_we    = we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
      end
      DONE: begin
        state_d  = IDLE;
        if_valid = ~owner_q;
        d_valid  = owner_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q    <= 1'b0;
      last_q     <= 1'b0;
      we_q       <= 1'b0;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      if (state_q == IDLE && any_req) begin
        owner_q <= gnt_d;
        addr_q  <= gnt_d ? d_addr : if_addr;
        we_q    <= gnt_d & d_we;
        wdata_q <= gnt_d ? d_wdata : '0;
        cnt_q   <= CW'(MEM_LAT);
      end
      if (state_q == BUSY) cnt_q <= cnt_q - CW'(1);
      if (last_beat) begin
        last_q <= owner_q;
        if (!we_q && owner_q) d_rdata_q <= mem_rdata;
        if (!we_q && !owner_q) if_rdata_q <= mem_rdata;
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench with per-port reference expectations and a behavioural memory.
module tb_mem_port_arbiter;
  localparam int W = 32, LAT = 2;
  logic clk = 1'b0, reset = 1'b1;
  logic if_req, d_req, d_we, if_valid, d_valid, stall_if, stall_mem, mem_en, mem_we;
  logic [W-1:0] if_addr, d_addr, d_wdata, if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [31:0] dmem [16] = '{default: 32'h0};
  logic [31:0] shadow [16];
  logic [31:0] if_q [$], d_q [$];
  logic [31:0] last_load = 32'h0;
  int checks = 0, errors = 0, cyc = 0, en_cnt = 0, if_wait = 0, d_wait = 0;
  always #5 clk = ~clk;
  mem_port_arbiter #(.DATA_W(W), .MEM_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_valid(if_valid), .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid), .stall_if(stall_if), .stall_mem(stall_mem),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );
  function automatic logic [31:0] imem(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h00500093;
  endfunction
  function automatic logic [31:0] dkey(input logic [3:0] i);
    return {16'hA5A5, {4{i}}};
  endfunction
  // Data region at 0x1000 holds 16 words; everything else is a fixed instruction pattern.
  always_comb mem_rdata = mem_addr[12] ? (dmem[mem_addr[5:2]] ^ dkey(mem_addr[5:2])) : imem(mem_addr);
  always @(posedge clk) if (mem_en && mem_we) dmem[mem_addr[5:2]] <= mem_wdata ^ dkey(mem_addr[5:2]);
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_en) en_cnt <= en_cnt + 1;
  end
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask
  task automatic miss(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got completion with empty expectation queue, expected none (cycle %0d)", name, cyc);
  endtask
  always @(negedge clk) begin
    if (reset) begin
      if_wait = 0;
      d_wait = 0;
    end else begin
      check("stall_if", 32'(stall_if), 32'(if_req & ~if_valid));
      check("stall_mem", 32'(stall_mem), 32'(d_req & ~d_valid));
      check("we_without_en", 32'(mem_we & ~mem_en), 32'h0);
      if (if_valid) begin
        check("both_valid", 32'(d_valid), 32'h0);
        if (if_q.size() == 0) miss("if_unexpected");
        else check("if_rdata", if_rdata, if_q.pop_front());
        check("if_wait_gt1", 32'(if_wait > 1), 32'h0);
        if_wait = 0;
        if (d_req) d_wait++;
      end
      if (d_valid) begin
        if (d_q.size() == 0) miss("d_unexpected");
        else check("d_rdata", d_rdata, d_q.pop_front());
        check("d_wait_gt1", 32'(d_wait > 1), 32'h0);
        d_wait = 0;
        if (if_req) if_wait++;
      end
    end
  end
  task automatic if_xfer(input logic [31:0] a, output int vc);
    int n;
    if_addr = a;
    if_req = 1'b1;
    if_q.push_back(imem(a));
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!if_valid && n < 50);
    vc = cyc;
    if (!if_valid) begin
      checks++;
      errors++;
      $display("FAIL if_timeout: no if_valid after %0d cycles, required within 50", n);
    end
    @(posedge clk);
    #1 if_req = 1'b0;
  endtask
  task automatic d_xfer(input logic we, input logic [3:0] idx, input logic [31:0] wd, output int vc);
    int n;
    d_we = we;
    d_addr = 32'h1000 + 32'(idx) * 4;
    d_wdata = wd;
    d_req = 1'b1;
    if (we) shadow[idx] = wd;
    else last_load = shadow[idx];
    d_q.push_back(last_load);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!d_valid && n < 50);
    vc = cyc;
    if (!d_valid) begin
      checks++;
      errors++;
      $display("FAIL d_timeout: no d_valid after %0d cycles, required within 50", n);
    end
    @(posedge clk);
    #1 d_req = 1'b0;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1);
  end
  initial begin
    int t, e0, va, vb, vc, vd;
    logic [31:0] a;
    for (int i = 0; i < 16; i++) shadow[i] = dkey(4'(i));
    if_req = 0; d_req = 0; d_we = 0; if_addr = 0; d_addr = 0; d_wdata = 0;
    @(posedge clk);
    #1;
    check("reset_en_we", {30'h0, mem_en, mem_we}, 32'h0);
    check("reset_addr", mem_addr, 32'h0);
    check("reset_wdata", mem_wdata, 32'h0);
    check("reset_if_rdata", if_rdata, 32'h0);
    check("reset_d_rdata", d_rdata, 32'h0);
    check("reset_valid", {30'h0, if_valid, d_valid}, 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    t = cyc;
    e0 = en_cnt;
    fork
      begin if_xfer(32'h10, va); if_xfer(32'h14, vb); end
      begin d_xfer(1'b0, 4'h0, 32'h0, vc); d_xfer(1'b0, 4'h1, 32'h0, vd); end
    join
    check("contest_d1_cycle", 32'(vc - t), 32'd3);
    check("contest_i1_cycle", 32'(va - t), 32'd7);
    check("contest_d2_cycle", 32'(vd - t), 32'd11);
    check("contest_i2_cycle", 32'(vb - t), 32'd15);
    check("contest_en_cycles", 32'(en_cnt - e0), 32'd8);
    t = cyc;
    e0 = en_cnt;
    if_xfer(32'h10, va);
    check("fetch_latency", 32'(va - t), 32'd3);
    repeat (3) @(posedge clk);
    #1 check("no_reissue_en_cycles", 32'(en_cnt - e0), 32'd2);
    t = cyc;
    e0 = en_cnt;
    d_xfer(1'b1, 4'h0, 32'hDEADBEEF, vc);
    check("store_latency", 32'(vc - t), 32'd3);
    check("store_en_cycles", 32'(en_cnt - e0), 32'd2);
    check("store_mem", dmem[0] ^ dkey(4'h0), 32'hDEADBEEF);
    if_addr = 32'h20;
    if_req = 1'b1;
    @(posedge clk);
    #1 check("busy_en", 32'(mem_en), 32'h1);
    reset = 1'b1;
    if_req = 1'b0;
    last_load = 32'h0;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("midreset_en", 32'(mem_en), 32'h0);
    check("midreset_valid", {30'h0, if_valid, d_valid}, 32'h0);
    check("midreset_rdata", if_rdata | d_rdata, 32'h0);
    @(posedge clk);
    #1 t = cyc;
    if_xfer(32'h24, va);
    check("postreset_latency", 32'(va - t), 32'd3);
    fork
      for (int i = 0; i < 40; i++) begin
        int k;
        k = $urandom_range(0, 3);
        if (k > 0) begin repeat (k) @(posedge clk); #1; end
        a = $urandom_range(0, 255) << 2;
        if_xfer(a, va);
      end
      for (int j = 0; j < 40; j++) begin
        int k;
        k = $urandom_range(0, 3);
        if (k > 0) begin repeat (k) @(posedge clk); #1; end
        d_xfer(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, vd);
      end
    join
    repeat (5) @(posedge clk);
    #1;
    check("if_q_drained", 32'(if_q.size()), 32'h0);
    check("d_q_drained", 32'(d_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
